// File: rtl/fuel_score_tracker_if.sv
// Bus bundle for fuel_score_tracker: game-controller inputs and tracker outputs.
interface fuel_score_tracker_if;
  logic        startOfFrame;
  logic        one_sec;
  logic        idle_request;
  logic [1:0]  speed;
  logic        addFuel;
  logic        addScore;
  logic        speedResetN;
  logic [6:0]  fuel;
  logic [13:0] score;
  logic [11:0] distance;
  logic        fuelLow;
  logic        GameOver;
  logic        GameWon;

  modport master (
    output startOfFrame, one_sec, idle_request, speed,
    output addFuel, addScore, speedResetN,
    input  fuel, score, distance, fuelLow, GameOver, GameWon
  );

  modport slave (
    input  startOfFrame, one_sec, idle_request, speed,
    input  addFuel, addScore, speedResetN,
    output fuel, score, distance, fuelLow, GameOver, GameWon
  );
endinterface

// File: rtl/fuel_score_tracker.sv
// Fuel / score / distance tracker for a driving game. Counters are live only
// in S_RUN; the game ends on empty fuel (takes priority) or on reaching
// WIN_DIST, and everything freezes until reset.
module fuel_score_tracker #(
  parameter int unsigned FUEL_MAX      = 100,
  parameter int unsigned FUEL_BONUS    = 20,
  parameter int unsigned CRASH_PENALTY = 10,
  parameter int unsigned SCORE_STEP    = 50,
  parameter int unsigned WIN_DIST      = 3000
) (
  input  logic                 clk,
  input  logic                 reset,
  fuel_score_tracker_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_OVER = 2'd2,
    S_WON  = 2'd3
  } state_t;

  localparam logic        [6:0]  FUEL_MAX_L = 7'(FUEL_MAX);
  localparam logic signed [8:0]  FUEL_MAX_S = 9'(FUEL_MAX);
  localparam logic signed [8:0]  BONUS_S    = 9'(FUEL_BONUS);
  localparam logic signed [8:0]  PENALTY_S  = 9'(CRASH_PENALTY);
  localparam logic        [6:0]  LOW_THRESH = 7'(FUEL_MAX / 5);
  localparam logic        [13:0] SCORE_MAX  = 14'd9999;
  localparam logic        [14:0] STEP_L     = 15'(SCORE_STEP);
  localparam logic        [11:0] WIN_L      = 12'(WIN_DIST);

  state_t        state_q, state_d;
  logic [6:0]    fuel_q, fuel_d;
  logic [13:0]   score_q, score_d;
  logic [11:0]   dist_q, dist_d;
  logic          low_q, low_d;
  logic          over_q, over_d;
  logic          won_q, won_d;

  logic          add_fuel_prev_q;
  logic          add_score_prev_q;
  logic          speed_rst_prev_q;

  logic          refuel_ev;
  logic          score_ev;
  logic          crash_ev;
  logic          burn_ev;
  logic signed [8:0] fuel_sum;
  logic [6:0]    fuel_clamped;
  logic [14:0]   score_sum;
  logic [13:0]   score_sat;
  logic [12:0]   dist_sum;
  logic [11:0]   dist_sat;

  // Edge registers follow the inputs in every state so entering S_RUN never sees a stale edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      add_fuel_prev_q  <= 1'b0;
      add_score_prev_q <= 1'b0;
      speed_rst_prev_q <= 1'b1;
    end else begin
      add_fuel_prev_q  <= bus.addFuel;
      add_score_prev_q <= bus.addScore;
      speed_rst_prev_q <= bus.speedResetN;
    end
  end

  // Event detection and saturating arithmetic for the running game.
  always_comb begin
    refuel_ev = bus.addFuel & ~add_fuel_prev_q;
    score_ev  = bus.addScore & ~add_score_prev_q;
    crash_ev  = ~bus.speedResetN & speed_rst_prev_q;
    burn_ev   = bus.one_sec & (bus.speed != 2'd0);

    // Fuel adjustments are summed signed first so a crash plus burn can go
    // below zero and a refuel above capacity before the single clamp.
    fuel_sum = $signed({2'b00, fuel_q});
    if (refuel_ev) fuel_sum = fuel_sum + BONUS_S;
    if (crash_ev)  fuel_sum = fuel_sum - PENALTY_S;
    if (burn_ev)   fuel_sum = fuel_sum - 9'sd1;

    if (fuel_sum < 9'sd0) begin
      fuel_clamped = '0;
    end else if (fuel_sum > FUEL_MAX_S) begin
      fuel_clamped = FUEL_MAX_L;
    end else begin
      fuel_clamped = fuel_sum[6:0];
    end

    score_sum = {1'b0, score_q} + STEP_L;
    if (score_sum >= {1'b0, SCORE_MAX}) begin
      score_sat = SCORE_MAX;
    end else begin
      score_sat = score_sum[13:0];
    end

    dist_sum = {1'b0, dist_q} + {11'b0, bus.speed};
    if (dist_sum >= {1'b0, WIN_L}) begin
      dist_sat = WIN_L;
    end else begin
      dist_sat = dist_sum[11:0];
    end
  end

  // Next-state and next-output logic; flags are derived from the next state
  // so GameOver/GameWon rise on the same edge the state changes.
  always_comb begin
    state_d = state_q;
    fuel_d  = fuel_q;
    score_d = score_q;
    dist_d  = dist_q;

    unique case (state_q)
      S_IDLE: begin
        fuel_d  = FUEL_MAX_L;
        score_d = '0;
        dist_d  = '0;
        if (!bus.idle_request) state_d = S_RUN;
      end
      S_RUN: begin
        // The exit cycle holds all counters; empty fuel wins over a tie.
        if (fuel_q == '0) begin
          state_d = S_OVER;
        end else if (dist_q == WIN_L) begin
          state_d = S_WON;
        end else begin
          fuel_d = fuel_clamped;
          if (score_ev)         score_d = score_sat;
          if (bus.startOfFrame) dist_d  = dist_sat;
        end
      end
      S_OVER, S_WON: begin
        state_d = state_q;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    low_d  = (fuel_d <= LOW_THRESH);
    over_d = (state_d == S_OVER);
    won_d  = (state_d == S_WON);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      fuel_q  <= FUEL_MAX_L;
      score_q <= '0;
      dist_q  <= '0;
      low_q   <= 1'b0;
      over_q  <= 1'b0;
      won_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      fuel_q  <= fuel_d;
      score_q <= score_d;
      dist_q  <= dist_d;
      low_q   <= low_d;
      over_q  <= over_d;
      won_q   <= won_d;
    end
  end

  assign bus.fuel     = fuel_q;
  assign bus.score    = score_q;
  assign bus.distance = dist_q;
  assign bus.fuelLow  = low_q;
  assign bus.GameOver = over_q;
  assign bus.GameWon  = won_q;

endmodule

// File: tb/tb_fuel_score_tracker.sv
// Directed bench for fuel_score_tracker: a table of per-cycle vectors on the
// default-parameter instance, plus hand sequences on a short-game instance.
module tb_fuel_score_tracker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, idle, sof, sec, af, as_, srn;
  logic [1:0] spd;

  fuel_score_tracker_if ifa ();
  fuel_score_tracker_if ifb ();

  assign ifa.startOfFrame = sof;
  assign ifa.one_sec      = sec;
  assign ifa.idle_request = idle;
  assign ifa.speed        = spd;
  assign ifa.addFuel      = af;
  assign ifa.addScore     = as_;
  assign ifa.speedResetN  = srn;

  assign ifb.startOfFrame = sof;
  assign ifb.one_sec      = sec;
  assign ifb.idle_request = idle;
  assign ifb.speed        = spd;
  assign ifb.addFuel      = af;
  assign ifb.addScore     = as_;
  assign ifb.speedResetN  = srn;

  fuel_score_tracker u_dut_a (
    .clk   (clk),
    .reset (rst),
    .bus   (ifa)
  );

  fuel_score_tracker #(
    .WIN_DIST   (30),
    .SCORE_STEP (45)
  ) u_dut_b (
    .clk   (clk),
    .reset (rst),
    .bus   (ifb)
  );

  // Input flag bits for the vector table.
  localparam int R  = 1;   // reset
  localparam int I  = 2;   // idle_request
  localparam int F  = 4;   // startOfFrame
  localparam int S  = 8;   // one_sec
  localparam int AF = 16;  // addFuel
  localparam int AS = 32;  // addScore
  localparam int CR = 64;  // speedResetN low

  typedef struct {
    int flags;
    int sp;
    bit c;
    int f;
    int s;
    int d;
    bit l;
    bit o;
    bit w;
  } vec_t;

  vec_t vq[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic void ck(input int fl, input int sp, input int f, input int s,
                             input int d, input bit l, input bit o, input bit w);
    vec_t v;
    v.flags = fl; v.sp = sp; v.c = 1'b1;
    v.f = f; v.s = s; v.d = d; v.l = l; v.o = o; v.w = w;
    vq.push_back(v);
  endfunction

  function automatic void nc(input int fl, input int sp);
    vec_t v;
    v.flags = fl; v.sp = sp; v.c = 1'b0;
    v.f = 0; v.s = 0; v.d = 0; v.l = 1'b0; v.o = 1'b0; v.w = 1'b0;
    vq.push_back(v);
  endfunction

  task automatic drive(input int fl, input int sp);
    rst  = (fl & R)  != 0;
    idle = (fl & I)  != 0;
    sof  = (fl & F)  != 0;
    sec  = (fl & S)  != 0;
    af   = (fl & AF) != 0;
    as_  = (fl & AS) != 0;
    srn  = (fl & CR) == 0;
    spd  = 2'(sp);
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input bit b, input string nm, input int f, input int s, input int d,
                     input bit l, input bit o, input bit w);
    logic [6:0]  af_o;
    logic [13:0] as_o;
    logic [11:0] ad_o;
    logic        al, ao, aw;
    if (b) begin
      af_o = ifb.fuel; as_o = ifb.score; ad_o = ifb.distance;
      al = ifb.fuelLow; ao = ifb.GameOver; aw = ifb.GameWon;
    end else begin
      af_o = ifa.fuel; as_o = ifa.score; ad_o = ifa.distance;
      al = ifa.fuelLow; ao = ifa.GameOver; aw = ifa.GameWon;
    end
    n_checks++;
    if ({af_o, as_o, ad_o, al, ao, aw} !== {7'(f), 14'(s), 12'(d), l, o, w}) begin
      n_fail++;
      $display("FAIL %s: got fuel=%0d score=%0d dist=%0d low=%0b over=%0b won=%0b, expected fuel=%0d score=%0d dist=%0d low=%0b over=%0b won=%0b",
               nm, af_o, as_o, ad_o, al, ao, aw, f, s, d, l, o, w);
    end
  endtask

  initial begin
    // ---- default instance: start, burn, refuel, crash, game over ----
    ck(R | I,  2, 100, 0, 0, 0, 0, 0);
    ck(I | AF, 2, 100, 0, 0, 0, 0, 0);
    ck(AF,     2, 100, 0, 0, 0, 0, 0);
    ck(AF | S, 2,  99, 0, 0, 0, 0, 0);   // held addFuel from idle is not an edge
    ck(S | I,  2,  98, 0, 0, 0, 0, 0);   // idle_request in run ignored
    for (int k = 0; k < 7; k++) nc(S, 2);
    ck(S,      2,  90, 0, 0, 0, 0, 0);
    ck(AF,     2, 100, 0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) nc(AF, 2);
    ck(AF,     2, 100, 0, 0, 0, 0, 0);
    nc(0, 2);
    for (int k = 0; k < 49; k++) nc(S, 2);
    ck(S,      2,  50, 0, 0, 0, 0, 0);
    ck(S | AF, 2,  69, 0, 0, 0, 0, 0);
    for (int k = 0; k < 47; k++) nc(S, 2);
    ck(S,      2,  21, 0, 0, 0, 0, 0);
    ck(S,      2,  20, 0, 0, 1, 0, 0);
    for (int k = 0; k < 14; k++) nc(S, 2);
    ck(S,      2,   5, 0, 0, 1, 0, 0);
    ck(CR,     2,   0, 0, 0, 1, 0, 0);
    ck(CR,     2,   0, 0, 0, 1, 1, 0);
    ck(CR,     2,   0, 0, 0, 1, 1, 0);
    nc(0, 2);
    ck(AF | S, 2,   0, 0, 0, 1, 1, 0);
    // ---- default instance: score and distance ----
    ck(R | I,  2, 100,   0, 0, 0, 0, 0);
    ck(0,      2, 100,   0, 0, 0, 0, 0);
    ck(AS,     2, 100,  50, 0, 0, 0, 0);
    ck(AS,     2, 100,  50, 0, 0, 0, 0);
    nc(0, 2);
    ck(AS,     2, 100, 100, 0, 0, 0, 0);
    nc(0, 2);
    ck(AS,     2, 100, 150, 0, 0, 0, 0);
    ck(F,      3, 100, 150, 3, 0, 0, 0);
    ck(F,      3, 100, 150, 6, 0, 0, 0);
    ck(F,      0, 100, 150, 6, 0, 0, 0);
    ck(S,      0, 100, 150, 6, 0, 0, 0);
    ck(F | S,  1,  99, 150, 7, 0, 0, 0);

    foreach (vq[k]) begin
      drive(vq[k].flags, vq[k].sp);
      if (vq[k].c) chk(1'b0, $sformatf("vec%0d", k), vq[k].f, vq[k].s, vq[k].d,
                       vq[k].l, vq[k].o, vq[k].w);
    end

    // ---- short-game instance: score saturation ----
    drive(R | I, 0);
    drive(0, 0);
    for (int k = 0; k < 222; k++) begin
      drive(AS, 0);
      drive(0, 0);
    end
    chk(1'b1, "score_9990", 100, 9990, 0, 0, 0, 0);
    drive(AS, 0);
    chk(1'b1, "score_sat", 100, 9999, 0, 0, 0, 0);
    drive(0, 0);
    drive(AS, 0);
    chk(1'b1, "score_sat_hold", 100, 9999, 0, 0, 0, 0);

    // ---- short-game instance: win, freeze, reset from S_WON ----
    drive(0, 3);
    for (int k = 0; k < 9; k++) drive(F, 3);
    chk(1'b1, "dist_27", 100, 9999, 27, 0, 0, 0);
    drive(F, 3);
    chk(1'b1, "dist_win", 100, 9999, 30, 0, 0, 0);
    drive(F, 3);
    chk(1'b1, "game_won", 100, 9999, 30, 0, 0, 1);
    drive(F | S | AF | AS, 3);
    chk(1'b1, "won_frozen", 100, 9999, 30, 0, 0, 1);
    drive(R | I, 3);
    chk(1'b1, "reset_in_won", 100, 0, 0, 0, 0, 0);
    drive(I | S | F, 3);
    chk(1'b1, "idle_no_burn", 100, 0, 0, 0, 0, 0);

    // ---- short-game instance: fuel empty and win on the same edge ----
    drive(R | I, 3);
    drive(0, 3);
    for (int k = 0; k < 9; k++) drive(F, 3);
    for (int k = 0; k < 9; k++) begin
      drive(CR, 3);
      drive(0, 3);
    end
    chk(1'b1, "tie_pre", 10, 0, 27, 1, 0, 0);
    drive(CR | F, 3);
    chk(1'b1, "tie_edge", 0, 0, 30, 1, 0, 0);
    drive(0, 3);
    chk(1'b1, "tie_over", 0, 0, 30, 1, 1, 0);
    drive(F, 3);
    chk(1'b1, "tie_hold", 0, 0, 30, 1, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
